// File: rtl/i2c_target_sync_if.sv
// rtl/i2c_target_sync_if.sv - user-side byte handshake of the clocked I2C target
interface i2c_target_sync_if;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_req;
  logic       addr_hit;
  logic       rw_bit;
  logic       busy;
  logic       sda_oe;

  modport slave (
    input  tx_data,
    output rx_data, rx_valid, tx_req, addr_hit, rw_bit, busy, sda_oe
  );

  modport master (
    output tx_data,
    input  rx_data, rx_valid, tx_req, addr_hit, rw_bit, busy, sda_oe
  );
endinterface

// File: rtl/i2c_target_sync.sv
// rtl/i2c_target_sync.sv - clock-oversampled I2C target: START/STOP detect, 7-bit address match,
// write byte reception and read byte transmission; sda is only ever pulled low.
module i2c_target_sync #(
  parameter logic [6:0] TARGET_ADDR = 7'b1010101
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scl,
  inout  wire              sda,
  i2c_target_sync_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_WAIT
  } state_t;

  state_t     state;
  logic [3:0] bit_cnt;
  logic [6:0] rx_shift;
  logic [7:0] tx_shift;
  logic       sda_oe_r;
  logic [7:0] rx_data_r;
  logic       rx_valid_r;
  logic       tx_req_r;
  logic       addr_hit_r;
  logic       rw_bit_r;
  logic       busy_r;

  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  logic       scl_hist;
  logic       sda_hist;
  logic       scl_s;
  logic       sda_s;
  logic       scl_rise;
  logic       scl_fall;
  logic       start_det;
  logic       stop_det;

  // Open-drain: a 1 on the wire always comes from the pull-up, never from us.
  assign sda = sda_oe_r ? 1'b0 : 1'bz;

  assign bus.rx_data  = rx_data_r;
  assign bus.rx_valid = rx_valid_r;
  assign bus.tx_req   = tx_req_r;
  assign bus.addr_hit = addr_hit_r;
  assign bus.rw_bit   = rw_bit_r;
  assign bus.busy     = busy_r;
  assign bus.sda_oe   = sda_oe_r;

  // Synchronizers idle high like the bus so leaving reset cannot fake a START.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_hist <= 1'b1;
      sda_hist <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl};
      sda_sync <= {sda_sync[0], sda};
      scl_hist <= scl_sync[1];
      sda_hist <= sda_sync[1];
    end
  end

  assign scl_s     = scl_sync[1];
  assign sda_s     = sda_sync[1];
  assign scl_rise  = scl_s & ~scl_hist;
  assign scl_fall  = ~scl_s & scl_hist;
  assign start_det = scl_s & scl_hist & sda_hist & ~sda_s;
  assign stop_det  = scl_s & scl_hist & ~sda_hist & sda_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      bit_cnt    <= 4'd0;
      rx_shift   <= 7'd0;
      tx_shift   <= 8'd0;
      sda_oe_r   <= 1'b0;
      rx_data_r  <= 8'd0;
      rx_valid_r <= 1'b0;
      tx_req_r   <= 1'b0;
      addr_hit_r <= 1'b0;
      rw_bit_r   <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      rx_valid_r <= 1'b0;
      tx_req_r   <= 1'b0;
      addr_hit_r <= 1'b0;
      if (start_det) begin
        state    <= ST_ADDR;
        bit_cnt  <= 4'd0;
        sda_oe_r <= 1'b0;
      end else if (stop_det) begin
        state    <= ST_IDLE;
        bit_cnt  <= 4'd0;
        sda_oe_r <= 1'b0;
        busy_r   <= 1'b0;
      end else begin
        case (state)
          ST_ADDR: begin
            // rx_shift holds the 7 address bits by the 8th rise; sda then carries R/W.
            if (scl_rise) begin
              if (bit_cnt == 4'd7) begin
                bit_cnt <= 4'd0;
                if (rx_shift == TARGET_ADDR) begin
                  addr_hit_r <= 1'b1;
                  rw_bit_r   <= sda_s;
                  busy_r     <= 1'b1;
                  state      <= ST_ADDR_ACK;
                end else begin
                  busy_r <= 1'b0;
                  state  <= ST_WAIT;
                end
              end else begin
                rx_shift <= {rx_shift[5:0], sda_s};
                bit_cnt  <= bit_cnt + 4'd1;
              end
            end
          end
          ST_ADDR_ACK: begin
            if (scl_fall) begin
              if (bit_cnt == 4'd0) begin
                sda_oe_r <= 1'b1;
                bit_cnt  <= 4'd1;
              end else if (rw_bit_r) begin
                tx_shift <= {bus.tx_data[6:0], 1'b0};
                tx_req_r <= 1'b1;
                sda_oe_r <= ~bus.tx_data[7];
                bit_cnt  <= 4'd1;
                state    <= ST_RD_DATA;
              end else begin
                sda_oe_r <= 1'b0;
                bit_cnt  <= 4'd0;
                state    <= ST_WR_DATA;
              end
            end
          end
          ST_WR_DATA: begin
            if (scl_rise) begin
              if (bit_cnt == 4'd7) begin
                rx_data_r  <= {rx_shift, sda_s};
                rx_valid_r <= 1'b1;
                bit_cnt    <= 4'd0;
                state      <= ST_WR_ACK;
              end else begin
                rx_shift <= {rx_shift[5:0], sda_s};
                bit_cnt  <= bit_cnt + 4'd1;
              end
            end
          end
          ST_WR_ACK: begin
            if (scl_fall) begin
              if (bit_cnt == 4'd0) begin
                sda_oe_r <= 1'b1;
                bit_cnt  <= 4'd1;
              end else begin
                sda_oe_r <= 1'b0;
                bit_cnt  <= 4'd0;
                state    <= ST_WR_DATA;
              end
            end
          end
          ST_RD_DATA: begin
            // bit_cnt counts bits already presented; the MSB went out on entry.
            if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe_r <= 1'b0;
                bit_cnt  <= 4'd0;
                state    <= ST_RD_ACK;
              end else begin
                sda_oe_r <= ~tx_shift[7];
                tx_shift <= {tx_shift[6:0], 1'b0};
                bit_cnt  <= bit_cnt + 4'd1;
              end
            end
          end
          ST_RD_ACK: begin
            if (scl_rise && bit_cnt == 4'd0) begin
              if (!sda_s) begin
                tx_shift <= bus.tx_data;
                tx_req_r <= 1'b1;
                bit_cnt  <= 4'd1;
              end else begin
                busy_r <= 1'b0;
                state  <= ST_WAIT;
              end
            end else if (scl_fall && bit_cnt == 4'd1) begin
              sda_oe_r <= ~tx_shift[7];
              tx_shift <= {tx_shift[6:0], 1'b0};
              state    <= ST_RD_DATA;
            end
          end
          default: begin
            sda_oe_r <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_sync.sv
// tb/tb_i2c_target_sync.sv - bus-level master bench for i2c_target_sync: table vectors, random transfers, reset mid-read
module tb_i2c_target_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic scl_m;
  logic m_sda;
  wire  sda;

  assign sda = m_sda ? 1'bz : 1'b0;
  pullup (sda);

  i2c_target_sync_if bus ();

  i2c_target_sync #(.TARGET_ADDR(7'h55)) dut (
    .clk(clk),
    .rst(rst),
    .scl(scl_m),
    .sda(sda),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  int         hit_cnt   = 0;
  int         txreq_cnt = 0;
  int         oe_cnt    = 0;
  logic       hit_rw    = 1'b0;
  logic       oe_prev   = 1'b0;
  logic [7:0] rx_log[$];

  always @(negedge clk) begin
    if (bus.addr_hit) begin
      hit_cnt <= hit_cnt + 1;
      hit_rw  <= bus.rw_bit;
    end
    if (bus.rx_valid) rx_log.push_back(bus.rx_data);
    if (bus.tx_req) txreq_cnt <= txreq_cnt + 1;
    if (bus.sda_oe && !oe_prev) oe_cnt <= oe_cnt + 1;
    oe_prev <= bus.sda_oe;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic hp();
    repeat (8) @(negedge clk);
  endtask

  task automatic clock_bit(input logic b, output logic seen);
    m_sda = b;
    hp();
    scl_m = 1'b1;
    hp();
    seen  = sda;
    scl_m = 1'b0;
  endtask

  task automatic bus_start();
    m_sda = 1'b1;
    hp();
    scl_m = 1'b1;
    hp();
    m_sda = 1'b0;
    hp();
    scl_m = 1'b0;
    hp();
  endtask

  task automatic bus_stop();
    m_sda = 1'b0;
    hp();
    scl_m = 1'b1;
    hp();
    m_sda = 1'b1;
    hp();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(d[i], s);
    clock_bit(1'b1, s);
    acked = ~s;
  endtask

  task automatic read_byte(input logic ack, input logic [7:0] next_tx, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      d[i] = s;
      if (i == 7) bus.tx_data = next_tx;
    end
    clock_bit(~ack, s);
  endtask

  task automatic do_xfer(input logic [6:0] addr, input logic rw, input int n, input logic [23:0] data,
                         input logic stop_after, output logic addr_ack, output logic all_ack,
                         output logic [23:0] got, output logic busy_mid, output logic busy_end);
    logic        a;
    logic [7:0]  r;
    logic [23:0] sh;
    got = '0;
    all_ack = 1'b1;
    bus.tx_data = data[23:16];
    bus_start();
    write_byte({addr, rw}, addr_ack);
    busy_mid = bus.busy;
    for (int k = 0; k < n; k++) begin
      if (!rw) begin
        sh = data << (8 * k);
        write_byte(sh[23:16], a);
        all_ack &= a;
      end else begin
        sh = data << (8 * (k + 1));
        read_byte(k != n - 1, sh[23:16], r);
        got = (got << 8) | {16'h0, r};
      end
    end
    busy_end = bus.busy;
    if (stop_after) bus_stop();
    repeat (4) @(negedge clk);
  endtask

  typedef struct {
    logic [6:0]  addr;
    logic        rw;
    int          n;
    logic [23:0] data;
    logic        stop;
    logic        exp_ack;
    logic [23:0] exp_got;
    int          exp_hits;
    int          exp_rx;
    int          exp_txreq;
    logic        exp_busy_end;
    logic [7:0]  exp_rxd;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic        ack, all_ack, busy_mid, busy_end, hit, s;
    logic [23:0] got, exp_got, sh;
    logic [6:0]  addr;
    logic        rw, stp;
    logic [23:0] data;
    int          n, h0, t0, o0, r0;
    logic [15:0] pat;

    //           addr   rw    n  data        stop  ack   got         hit rx tx busy  rxd
    vecs[0] = '{7'h55, 1'b0, 1, 24'hAA0000, 1'b1, 1'b1, 24'h000000, 1, 1, 0, 1'b1, 8'hAA};
    vecs[1] = '{7'h55, 1'b1, 1, 24'h290000, 1'b1, 1'b1, 24'h000029, 1, 0, 1, 1'b0, 8'hAA};
    vecs[2] = '{7'h55, 1'b1, 2, 24'h29C300, 1'b1, 1'b1, 24'h0029C3, 1, 0, 2, 1'b0, 8'hAA};
    vecs[3] = '{7'h54, 1'b0, 1, 24'h5A0000, 1'b1, 1'b0, 24'h000000, 0, 0, 0, 1'b0, 8'hAA};
    vecs[4] = '{7'h55, 1'b0, 1, 24'h110000, 1'b0, 1'b1, 24'h000000, 1, 1, 0, 1'b1, 8'h11};
    vecs[5] = '{7'h55, 1'b1, 1, 24'h7E0000, 1'b1, 1'b1, 24'h00007E, 1, 0, 1, 1'b0, 8'h11};

    rst = 1'b1;
    scl_m = 1'b1;
    m_sda = 1'b1;
    bus.tx_data = 8'h00;
    repeat (5) @(negedge clk);
    check("reset_outputs", {bus.rx_data, bus.rx_valid, bus.tx_req, bus.addr_hit, bus.rw_bit, bus.busy, bus.sda_oe}, 32'h0);
    check("reset_sda_line", sda, 1'b1);
    rst = 1'b0;
    hp();

    for (int i = 0; i < 6; i++) begin
      h0 = hit_cnt; t0 = txreq_cnt; o0 = oe_cnt; r0 = rx_log.size();
      do_xfer(vecs[i].addr, vecs[i].rw, vecs[i].n, vecs[i].data, vecs[i].stop, ack, all_ack, got, busy_mid, busy_end);
      check($sformatf("vec%0d_addr_ack", i), ack, vecs[i].exp_ack);
      check($sformatf("vec%0d_hits", i), hit_cnt - h0, vecs[i].exp_hits);
      check($sformatf("vec%0d_rx_valids", i), rx_log.size() - r0, vecs[i].exp_rx);
      check($sformatf("vec%0d_tx_reqs", i), txreq_cnt - t0, vecs[i].exp_txreq);
      check($sformatf("vec%0d_rx_data", i), bus.rx_data, vecs[i].exp_rxd);
      check($sformatf("vec%0d_busy_end", i), busy_end, vecs[i].exp_busy_end);
      if (vecs[i].rw) check($sformatf("vec%0d_read_bytes", i), got, vecs[i].exp_got);
      else            check($sformatf("vec%0d_data_acks", i), all_ack, vecs[i].exp_ack);
      if (vecs[i].exp_hits > 0) check($sformatf("vec%0d_rw_bit", i), hit_rw, vecs[i].rw);
      else                      check($sformatf("vec%0d_no_sda_drive", i), oe_cnt - o0, 0);
      if (vecs[i].stop) check($sformatf("vec%0d_busy_after_stop", i), bus.busy, 1'b0);
    end

    for (int i = 0; i < 24; i++) begin
      addr = ($urandom % 2 == 0) ? 7'h55 : 7'($urandom);
      rw   = 1'($urandom);
      n    = 1 + int'($urandom % 3);
      data = 24'($urandom);
      stp  = (i == 23) || ($urandom % 3 != 0);
      hit  = (addr == 7'h55);
      if (!rw)     exp_got = 24'h0;
      else if (hit) exp_got = data >> (8 * (3 - n));
      else          exp_got = (24'h1 << (8 * n)) - 24'h1;
      h0 = hit_cnt; t0 = txreq_cnt; o0 = oe_cnt; r0 = rx_log.size();
      do_xfer(addr, rw, n, data, stp, ack, all_ack, got, busy_mid, busy_end);
      check($sformatf("rnd%0d_addr_ack", i), ack, hit);
      check($sformatf("rnd%0d_hits", i), hit_cnt - h0, hit ? 1 : 0);
      check($sformatf("rnd%0d_busy_mid", i), busy_mid, hit);
      check($sformatf("rnd%0d_busy_end", i), busy_end, hit && !rw);
      check($sformatf("rnd%0d_tx_reqs", i), txreq_cnt - t0, (hit && rw) ? n : 0);
      check($sformatf("rnd%0d_rx_valids", i), rx_log.size() - r0, (hit && !rw) ? n : 0);
      check($sformatf("rnd%0d_read_bytes", i), got, exp_got);
      if (!hit) check($sformatf("rnd%0d_no_sda_drive", i), oe_cnt - o0, 0);
      if (hit && !rw) begin
        check($sformatf("rnd%0d_data_acks", i), all_ack, 1'b1);
        for (int k = 0; k < n; k++) begin
          sh = data << (8 * k);
          if (r0 + k < rx_log.size()) check($sformatf("rnd%0d_rx_byte%0d", i, k), rx_log[r0 + k], sh[23:16]);
        end
      end
    end

    // Reset asserted while the target pulls sda low for the MSB of 0x29.
    bus.tx_data = 8'h29;
    bus_start();
    write_byte({7'h55, 1'b1}, ack);
    check("rst_pre_addr_ack", ack, 1'b1);
    repeat (6) @(negedge clk);
    check("rst_pre_driving", bus.sda_oe, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_sda_oe", bus.sda_oe, 1'b0);
    check("rst_async_sda_line", sda, 1'b1);
    check("rst_async_outputs", {bus.rx_data, bus.rx_valid, bus.tx_req, bus.addr_hit, bus.rw_bit, bus.busy}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    h0 = hit_cnt; o0 = oe_cnt; r0 = rx_log.size();
    pat = {8'hAA, 8'h00};
    for (int i = 15; i >= 0; i--) clock_bit(pat[i], s);
    check("post_rst_ignored_hits", hit_cnt - h0, 0);
    check("post_rst_ignored_oe", oe_cnt - o0, 0);
    check("post_rst_ignored_rx", rx_log.size() - r0, 0);
    check("post_rst_busy", bus.busy, 1'b0);
    bus_stop();
    do_xfer(7'h55, 1'b0, 1, 24'h3C0000, 1'b1, ack, all_ack, got, busy_mid, busy_end);
    check("post_rst_addr_ack", ack, 1'b1);
    check("post_rst_rx_data", bus.rx_data, 8'h3C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_target_sync.md
Name: i2c_target_sync

Overview:
- Clock-synchronous I2C target (responder) that pairs with the team's I2C master block on a shared SCL/SDA bus.
- Oversamples SCL/SDA with the system clock, detects START/STOP, and matches a 7-bit address.
- Receives data bytes on writes and drives supplied bytes on reads.
- Replaces the unclocked behavioural slave wherever a synthesizable target is required.

Parameters:
- TARGET_ADDR, 7'b1010101, 7-bit bus address this target answers to.

Ports:
- clk  input  1  system clock; must be ≥8× SCL frequency.
- rst  input  1  reset; asynchronous, active-high.
- scl  input  1  bus clock from master.
- sda  inout  1  bus data; this block drives only 0 (when sda_oe=1), otherwise Z.
- tx_data  input  8  byte returned on read transfers; sampled when tx_req pulses.
- rx_data  output  8  last byte written by master.
- rx_valid  output  1  one-clk pulse when rx_data updates.
- tx_req  output  1  one-clk pulse when tx_data is latched for shifting.
- addr_hit  output  1  one-clk pulse on address match; rw_bit valid alongside.
- rw_bit  output  1  R/W bit of current transfer (1 = read).
- busy  output  1  high from matched address until STOP/NACK/IDLE.

Behaviour:
- Reset values:
  - rx_data=0, rx_valid=0, tx_req=0, addr_hit=0, rw_bit=0, busy=0.
  - sda_oe=0 (sda=Z), state=IDLE, bit counter=0.
- Reset mid-transfer: sda released immediately (asynchronous), all state cleared.
- Input conditioning:
  - scl and sda each pass through a 2-flop synchronizer plus one history register.
  - Edge and condition detection therefore lags the pin by 3 clk.
  - SCL high and low phases must each be ≥4 clk.
- Bus conditions:
  - START: synced sda falls while synced scl high. From any state → ADDR, bit count=0, sda released.
  - STOP: synced sda rises while synced scl high. From any state → IDLE, busy=0.
  - Repeated START behaves exactly like START.
  - A START/STOP event takes priority over any scl edge detected in the same clk.
- Sampling on SCL rising edge, updating on SCL falling edge:
  - sda is sampled on detected SCL rising edges.
  - sda_oe changes only on detected SCL falling edges, within 1 clk of detection.
- States:
  - IDLE: sda released; ignore scl.
  - ADDR: shift 8 bits MSB first (7 address + R/W). After the 8th rising edge:
    - Match → pulse addr_hit, set rw_bit and busy.
    - Mismatch → WAIT.
  - ADDR_ACK: on the next falling edge assert sda_oe. On the following falling edge:
    - rw=0 → release sda, go to WR_DATA.
    - rw=1 → load tx_data, pulse tx_req, drive MSB, go to RD_DATA.
  - WR_DATA: shift 8 bits. After the 8th rising edge: rx_data←byte, pulse rx_valid, go to WR_ACK.
  - WR_ACK: assert sda_oe on the next falling edge; release on the following falling edge; → WR_DATA with bit count=0.
  - RD_DATA:
    - Each falling edge presents the next bit: sda_oe = ~bit.
    - After the 8th bit's falling edge, release sda and go to RD_ACK.
  - RD_ACK: sample master ack on the 9th rising edge.
    - 0 (ACK) → load tx_data, pulse tx_req; on the next falling edge drive MSB; → RD_DATA.
    - 1 (NACK) → WAIT, busy=0.
  - WAIT: sda released; ignore everything until START/STOP.
- Bus contention: the target never drives sda high. Bit 1 is expressed as sda_oe=0.
- Bit counter is 4 bits and resets to 0 on every byte boundary. No wrap beyond 8.
- Data bytes are unlimited per transfer. rx_data is overwritten each byte; no buffering. The consumer must take rx_data within one byte time.

Test Plan:
- Write, address match:
  - Stimulus: master writes addr 0x55 rw=0, data 0xAA.
  - Required: target pulls sda low in both 9th-bit slots; addr_hit pulses once with rw_bit=0; rx_data=0xAA with a single rx_valid pulse; busy drops after STOP.
- Read, single byte:
  - Stimulus: addr 0x55 rw=1, tx_data=0x29, master NACKs.
  - Required: sda bits on SCL highs read 0,0,1,0,1,0,0,1; tx_req pulses once; WAIT until STOP, then IDLE.
- Read, two bytes:
  - Stimulus: tx_data=0x29, then 0xC3; master ACKs first byte, NACKs second.
  - Required: two tx_req pulses; second byte on bus is 1,1,0,0,0,0,1,1.
- Address mismatch:
  - Stimulus: addr 0x54.
  - Required: sda_oe never asserts; no addr_hit/rx_valid pulse; target ignores the data byte; STOP returns it to IDLE.
- Repeated START:
  - Stimulus: write 0x55 + 0x11, repeated START, read 0x55 with tx_data=0x7E.
  - Required: rx_data=0x11, then 0x7E driven; rw_bit switches 0→1 at the second addr_hit.
- Reset mid-read:
  - Stimulus: assert rst while the target drives sda low during RD_DATA.
  - Required: sda=Z immediately with no clk edge needed; all outputs at reset values; after rst release the target ignores the bus until the next START.
